// File: rtl/shift_sequencer.sv
// Iterative 16-bit shifter (SLL/SRA/ROR): one binary-weighted pass per clock, result 4 cycles after accept.
// Zero-amount and illegal-mode ops finish on the accept edge. The result is held until result_ready; start_ready only in IDLE.
module shift_sequencer #(
    parameter bit FAST_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [1:0]  Mode,
    input  logic [15:0] Data,
    input  logic [3:0]  Shamt,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [15:0] Result,
    output logic        Err,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_acc;
    logic [3:0]  r_shamt;
    logic [1:0]  r_mode;
    logic [1:0]  r_k;
    logic [15:0] r_result;
    logic        r_err;
    logic        r_valid;

    logic [3:0]  w_pass_amt;
    logic [15:0] w_shifted;

    // Single shift stage; n is always a power of two (1, 2, 4 or 8) here.
    function automatic logic [15:0] f_pass(input logic [15:0] x, input logic [1:0] mode,
                                           input logic [3:0] n);
        logic [15:0] y;
        y = x;
        case (mode)
            2'b00:   y = x << n;
            2'b01:   y = 16'($signed(x) >>> n);
            2'b10:   y = (x >> n) | (x << (5'd16 - {1'b0, n}));
            default: y = x;
        endcase
        return y;
    endfunction

    assign w_pass_amt = 4'b0001 << r_k;
    assign w_shifted  = r_shamt[r_k] ? f_pass(r_acc, r_mode, w_pass_amt) : r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_acc    <= 16'd0;
            r_shamt  <= 4'd0;
            r_mode   <= 2'd0;
            r_k      <= 2'd0;
            r_result <= 16'd0;
            r_err    <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_valid) begin
                        r_acc   <= Data;
                        r_shamt <= Shamt;
                        r_mode  <= Mode;
                        r_k     <= 2'd0;
                        if (Mode == 2'b11) begin
                            r_state  <= S_DONE;
                            r_result <= Data;
                            r_err    <= 1'b1;
                            r_valid  <= 1'b1;
                        end else if (FAST_ZERO && (Shamt == 4'd0)) begin
                            r_state  <= S_DONE;
                            r_result <= Data;
                            r_err    <= 1'b0;
                            r_valid  <= 1'b1;
                        end else begin
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    r_acc <= w_shifted;
                    r_k   <= r_k + 2'd1;
                    if (r_k == 2'd3) begin
                        r_state  <= S_DONE;
                        r_result <= w_shifted;
                        r_err    <= 1'b0;
                        r_valid  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (result_ready) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign start_ready  = (r_state == S_IDLE);
    assign busy         = (r_state != S_IDLE);
    assign result_valid = r_valid;
    assign Result       = r_result;
    assign Err          = r_err;

endmodule

// File: tb/tb_shift_sequencer.sv
// Random and directed ops on two sequencers (FAST_ZERO=1 and 0) sharing one request stream, checked against a whole-amount shift model.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_valid;
    logic [1:0]  Mode;
    logic [15:0] Data;
    logic [3:0]  Shamt;
    logic        result_ready;

    logic        a_start_ready, a_valid, a_err, a_busy;
    logic [15:0] a_result;
    logic        b_start_ready, b_valid, b_err, b_busy;
    logic [15:0] b_result;

    int n_checks;
    int n_fail;

    always #5 clk = ~clk;

    shift_sequencer #(.FAST_ZERO(1'b1)) u_dut_fz (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(a_start_ready),
        .Mode(Mode), .Data(Data), .Shamt(Shamt), .result_valid(a_valid),
        .result_ready(result_ready), .Result(a_result), .Err(a_err), .busy(a_busy)
    );

    shift_sequencer #(.FAST_ZERO(1'b0)) u_dut_nz (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(b_start_ready),
        .Mode(Mode), .Data(Data), .Shamt(Shamt), .result_valid(b_valid),
        .result_ready(result_ready), .Result(b_result), .Err(b_err), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Whole-amount shift: the four weighted passes must add up to this.
    function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [1:0] m,
                                              input int s);
        logic [31:0] dbl;
        logic [15:0] r;
        case (m)
            2'b00:   r = 16'(d << s);
            2'b01:   r = 16'($signed(d) >>> s);
            2'b10:   begin dbl = {d, d}; dbl = dbl >> s; r = dbl[15:0]; end
            default: r = d;
        endcase
        return r;
    endfunction

    // Index of the first edge after which result_valid is seen (accept edge = 0).
    function automatic int exp_lat(input logic [1:0] m, input logic [3:0] s, input bit fz);
        if (m == 2'b11) return 0;
        if (fz && s == 4'd0) return 0;
        return 4;
    endfunction

    task automatic wait_idle();
        int w;
        w = 0;
        @(negedge clk);
        while (!(a_start_ready && b_start_ready) && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("start_ready_wait", {30'd0, a_start_ready, b_start_ready}, 32'd3);
    endtask

    task automatic run_op(input logic [15:0] d, input logic [1:0] m, input logic [3:0] s,
                          input int hold);
        int la, lb;
        logic [15:0] er;
        logic ee;
        er = ref_shift(d, m, int'(s));
        ee = (m == 2'b11);
        wait_idle();
        Data = d; Mode = m; Shamt = s;
        start_valid = 1'b1;
        result_ready = 1'b1;  // ignored outside DONE
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        result_ready = 1'b0;
        Data = 16'($urandom); Mode = 2'($urandom); Shamt = 4'($urandom);
        la = -1; lb = -1;
        for (int e = 0; e < 10; e++) begin
            @(negedge clk);
            if (a_valid && la < 0) la = e;
            if (b_valid && lb < 0) lb = e;
            if (la >= 0 && lb >= 0) break;
        end
        chk("latency_fz", 32'(la), 32'(exp_lat(m, s, 1'b1)));
        chk("latency_nz", 32'(lb), 32'(exp_lat(m, s, 1'b0)));
        chk("result_fz", {16'd0, a_result}, {16'd0, er});
        chk("result_nz", {16'd0, b_result}, {16'd0, er});
        chk("err_fz", {31'd0, a_err}, {31'd0, ee});
        chk("err_nz", {31'd0, b_err}, {31'd0, ee});
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", {30'd0, a_valid, b_valid}, 32'd3);
            chk("hold_result", {a_result, b_result}, {er, er});
            chk("hold_start_ready", {30'd0, a_start_ready, b_start_ready}, 32'd0);
        end
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        @(negedge clk);
        chk("post_hs_valid", {30'd0, a_valid, b_valid}, 32'd0);
        chk("post_hs_start_ready", {30'd0, a_start_ready, b_start_ready}, 32'd3);
        chk("post_hs_result_kept", {a_result, b_result}, {er, er});
    endtask

    task automatic reset_mid_shift();
        bit seen;
        wait_idle();
        Data = 16'h8001; Mode = 2'b00; Shamt = 4'd4;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_busy", {30'd0, a_busy, b_busy}, 32'd3);
        rst_n = 1'b0;
        #1;
        chk("rst_valid", {30'd0, a_valid, b_valid}, 32'd0);
        chk("rst_result", {a_result, b_result}, 32'd0);
        chk("rst_busy", {30'd0, a_busy, b_busy}, 32'd0);
        chk("rst_err", {30'd0, a_err, b_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (a_valid || b_valid) seen = 1'b1;
        end
        chk("no_result_after_rst", {31'd0, seen}, 32'd0);
        chk("ready_after_rst", {30'd0, a_start_ready, b_start_ready}, 32'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b1;
        start_valid = 1'b0;
        result_ready = 1'b0;
        Data = 16'd0; Mode = 2'd0; Shamt = 4'd0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_valid", {30'd0, a_valid, b_valid}, 32'd0);
        chk("reset_result", {a_result, b_result}, 32'd0);
        chk("reset_err", {30'd0, a_err, b_err}, 32'd0);
        chk("reset_busy", {30'd0, a_busy, b_busy}, 32'd0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_start_ready", {30'd0, a_start_ready, b_start_ready}, 32'd3);

        run_op(16'h8001, 2'b00, 4'd4, 0);
        chk("dir_sll", {16'd0, a_result}, 32'h0010);
        run_op(16'h8001, 2'b01, 4'd4, 0);
        chk("dir_sra", {16'd0, a_result}, 32'hF800);
        run_op(16'h8001, 2'b10, 4'd4, 0);
        chk("dir_ror", {16'd0, a_result}, 32'h1800);
        run_op(16'h8001, 2'b10, 4'd15, 0);
        chk("dir_ror15", {16'd0, a_result}, 32'h0003);
        run_op(16'h7FFF, 2'b01, 4'd15, 0);
        chk("dir_sra15", {16'd0, a_result}, 32'h0000);
        run_op(16'hA5A5, 2'b00, 4'd0, 0);
        chk("dir_zero", {16'd0, a_result}, 32'hA5A5);
        run_op(16'h1234, 2'b11, 4'd7, 0);
        chk("dir_illegal_err", {31'd0, a_err}, 32'd1);
        run_op(16'h00F0, 2'b00, 4'd1, 0);
        chk("dir_err_cleared", {31'd0, a_err}, 32'd0);
        run_op(16'hC3C3, 2'b10, 4'd9, 10);

        reset_mid_shift();

        for (int i = 0; i < 40; i++) begin
            logic [1:0] m;
            logic [3:0] s;
            m = 2'($urandom_range(0, 3));
            s = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            run_op(16'($urandom), m, s, int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
